// File: rtl/ide_dma_seq_pkg.sv
// Shared IDE DMA definitions: sequencer states and transfer geometry.
package ide_dma_seq_pkg;

    localparam int DATA_W     = 16;
    localparam int SECT_WORDS = 256;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DRQ,
        FETCH,
        ISSUE,
        WAIT_END,
        NEXT
    } state_t;

endpackage

// File: rtl/ide_dma_seq.sv
// IDE DMA sequencer: walks sectors word by word, handing each word to the
// IDE cycle engine and moving data between the drive bus and memory.
module ide_dma_seq
    import ide_dma_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rnw,
    input  logic [7:0]        num_sect,
    input  logic              abort,
    input  logic              drq,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              dma_req,
    output logic              dma_rnw,
    output logic [DATA_W-1:0] dma_out,
    input  logic [DATA_W-1:0] ide_in,
    input  logic              rdy,
    input  logic              rdy_stb,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_rready
);

    state_t      state, state_next;
    logic        rnw_q;
    logic [7:0]  word_cnt;
    logic [8:0]  sect_left;
    logic        done_q, aborted_q;
    logic        start_acc, fetch_hs, word_wrap, finish, finish_abort;

    // The engine's idle flag is implied by the strobe handshake; kept for the port contract.
    logic unused_rdy;
    assign unused_rdy = rdy;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        start_acc    = 1'b0;
        fetch_hs     = 1'b0;
        finish       = 1'b0;
        finish_abort = 1'b0;
        mem_rready   = 1'b0;
        dma_req      = 1'b0;
        word_wrap    = (word_cnt == 8'(SECT_WORDS - 1));
        case (state)
            IDLE: begin
                // Holding off during the done cycle keeps done/aborted clear of an accepted start.
                if (start && !done_q) begin
                    start_acc  = 1'b1;
                    state_next = WAIT_DRQ;
                end
            end
            WAIT_DRQ: begin
                if (abort) begin
                    finish       = 1'b1;
                    finish_abort = 1'b1;
                    state_next   = IDLE;
                end else if (drq) begin
                    state_next = rnw_q ? ISSUE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    finish       = 1'b1;
                    finish_abort = 1'b1;
                    state_next   = IDLE;
                end else begin
                    mem_rready = 1'b1;
                    if (mem_rvalid) begin
                        fetch_hs   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                dma_req    = 1'b1;
                state_next = WAIT_END;
            end
            WAIT_END: begin
                dma_req = 1'b1;
                if (rdy_stb) state_next = NEXT;
            end
            NEXT: begin
                if (abort) begin
                    finish       = 1'b1;
                    finish_abort = 1'b1;
                    state_next   = IDLE;
                end else if (word_wrap) begin
                    if (sect_left == 9'd1) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_DRQ;
                    end
                end else begin
                    state_next = rnw_q ? ISSUE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q && !start_acc;
    assign dma_rnw = dma_req && rnw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rnw_q     <= 1'b0;
            word_cnt  <= '0;
            sect_left <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            mem_we    <= 1'b0;
            dma_out   <= '0;
            mem_wdata <= '0;
        end else begin
            done_q <= finish;
            mem_we <= 1'b0;
            if (start_acc) begin
                rnw_q     <= rnw;
                word_cnt  <= '0;
                sect_left <= (num_sect == 8'd0) ? 9'd256 : {1'b0, num_sect};
                aborted_q <= 1'b0;
            end
            if (finish_abort) aborted_q <= 1'b1;
            if (fetch_hs) dma_out <= mem_rdata;
            if (state == WAIT_END && rdy_stb && rnw_q) begin
                mem_wdata <= ide_in;
                mem_we    <= 1'b1;
            end
            if (state == NEXT) begin
                word_cnt <= word_cnt + 8'd1;
                if (word_wrap && !abort) sect_left <= sect_left - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_ide_dma_seq.sv
// Scoreboard bench for ide_dma_seq with an IDE engine model and a memory source.
module tb_ide_dma_seq;

    logic        clk = 1'b0;
    logic        reset, start, rnw, abort, drq;
    logic [7:0]  num_sect;
    logic        busy, done, aborted, dma_req, dma_rnw, mem_we, mem_rready;
    logic [15:0] dma_out, mem_wdata;
    logic [15:0] ide_in = 16'h0;
    logic        rdy, rdy_stb = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_rvalid = 1'b0;

    always #5 clk = ~clk;

    ide_dma_seq dut (
        .clk(clk), .reset(reset), .start(start), .rnw(rnw), .num_sect(num_sect),
        .abort(abort), .drq(drq), .busy(busy), .done(done), .aborted(aborted),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_out(dma_out), .ide_in(ide_in),
        .rdy(rdy), .rdy_stb(rdy_stb), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] rq[$];
    logic [15:0] wq[$];
    int   gos = 0, we_cnt = 0, done_cnt = 0, rd_idx = 0, wr_idx = 0;
    logic last_aborted = 1'b0, busy_at_done = 1'b0;
    int   eng_delay = 5, eng_cnt = 0;
    logic eng_busy = 1'b0;
    logic exp_rnw = 1'b1;
    logic src_en = 1'b0;

    assign rdy = !eng_busy;

    function automatic logic [15:0] rd_pat(input int i);
        return 16'(i * 16'h0123) ^ 16'hA55A;
    endfunction

    function automatic logic [15:0] wr_pat(input int i);
        return 16'(i * 16'h0351) + 16'h1F00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // IDE cycle engine: one cycle per dma_req rise, strobe eng_delay cycles later.
    always @(negedge clk) begin
        if (reset) begin
            eng_busy = 1'b0;
            rdy_stb  = 1'b0;
            eng_cnt  = 0;
        end else begin
            rdy_stb = 1'b0;
            if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_busy = 1'b0;
                    rdy_stb  = 1'b1;
                    if (exp_rnw) begin
                        ide_in = rd_pat(rd_idx);
                        rq.push_back(ide_in);
                        rd_idx++;
                    end
                end
            end else if (dma_req) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_delay;
                gos++;
                check("dma_rnw", dma_rnw, exp_rnw);
                if (!exp_rnw) begin
                    check("write queue has word", wq.size() != 0, 1);
                    if (wq.size() != 0) check("dma_out", dma_out, wq.pop_front());
                end
            end
        end
    end

    // Memory source: mem_rvalid toggles every cycle; accepted words go to the scoreboard.
    always @(negedge clk) begin
        if (reset || !src_en) begin
            mem_rvalid = 1'b0;
        end else begin
            mem_rvalid = ~mem_rvalid;
            mem_rdata  = wr_pat(wr_idx);
            #1;
            if (mem_rvalid && mem_rready) begin
                wq.push_back(mem_rdata);
                wr_idx++;
            end
        end
    end

    // Monitor: memory writes and done pulses.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            check("read queue has word", rq.size() != 0, 1);
            if (rq.size() != 0) check("mem_wdata", mem_wdata, rq.pop_front());
        end
        if (done) begin
            done_cnt++;
            last_aborted = aborted;
            busy_at_done = busy;
        end
    end

    task automatic pulse_start(input logic r, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1; rnw = r; num_sect = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, done_cnt - base, 1);
    endtask

    task automatic wait_gos(input int target, input int budget, input string name);
        int k = 0;
        while (gos < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, gos >= target, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, w0, d0, x0, gg, gap_req;
        reset = 1'b1; start = 1'b0; rnw = 1'b0; num_sect = 8'd0; abort = 1'b0; drq = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset aborted", aborted, 0);
        check("reset dma_req", dma_req, 0);
        check("reset dma_rnw", dma_rnw, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_rready", mem_rready, 0);
        check("reset dma_out", dma_out, 0);
        check("reset mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Read, one sector, engine strobe 5 cycles after go; a start mid-transfer is ignored.
        exp_rnw = 1'b1; eng_delay = 5;
        g0 = gos; w0 = we_cnt; d0 = done_cnt;
        pulse_start(1'b1, 8'd1);
        check("read busy after start", busy, 1);
        wait_gos(g0 + 100, 2000, "read reaches word 100");
        pulse_start(1'b0, 8'd5);
        wait_done(d0, 6000, "read done");
        repeat (4) @(negedge clk);
        check("read engine cycles", gos - g0, 256);
        check("read mem_we pulses", we_cnt - w0, 256);
        check("read scoreboard drained", rq.size(), 0);
        check("read single done", done_cnt - d0, 1);
        check("read aborted", last_aborted, 0);
        check("read busy at done", busy_at_done, 0);

        // Write, two sectors, mem_rvalid at 50%.
        exp_rnw = 1'b0; eng_delay = 2; src_en = 1'b1;
        g0 = gos; x0 = wr_idx; d0 = done_cnt;
        pulse_start(1'b0, 8'd2);
        wait_done(d0, 10000, "write done");
        check("write engine cycles", gos - g0, 512);
        check("write words fetched", wr_idx - x0, 512);
        check("write scoreboard drained", wq.size(), 0);
        check("write aborted", last_aborted, 0);
        src_en = 1'b0;
        repeat (3) @(negedge clk);

        // drq held low for 20 cycles across the sector boundary.
        exp_rnw = 1'b1; eng_delay = 4;
        g0 = gos; w0 = we_cnt; d0 = done_cnt;
        pulse_start(1'b1, 8'd2);
        wait_gos(g0 + 256, 4000, "gap reaches word 256");
        drq = 1'b0;
        for (int k = 0; k < 50 && dma_req; k++) @(negedge clk);
        gg = gos; gap_req = 0;
        repeat (20) begin
            @(negedge clk);
            if (dma_req) gap_req++;
        end
        check("gap dma_req cycles", gap_req, 0);
        check("gap no new words", gos - gg, 0);
        check("gap still busy", busy, 1);
        drq = 1'b1;
        wait_done(d0, 6000, "gap done");
        check("gap engine cycles", gos - g0, 512);
        check("gap mem_we pulses", we_cnt - w0, 512);

        // Abort raised while word 10 is in flight.
        g0 = gos; w0 = we_cnt; d0 = done_cnt;
        pulse_start(1'b1, 8'd1);
        wait_gos(g0 + 11, 500, "abort reaches word 10");
        abort = 1'b1;
        wait_done(d0, 100, "abort done");
        check("abort engine cycles", gos - g0, 11);
        check("abort mem_we pulses", we_cnt - w0, 11);
        check("abort aborted", last_aborted, 1);
        check("abort busy at done", busy_at_done, 0);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("aborted sticky in idle", aborted, 1);

        // Abort while waiting for drq ends at once; abort in IDLE does nothing.
        drq = 1'b0;
        g0 = gos; d0 = done_cnt;
        pulse_start(1'b1, 8'd1);
        repeat (3) @(negedge clk);
        check("wait_drq busy", busy, 1);
        abort = 1'b1;
        wait_done(d0, 3, "wait_drq abort done");
        check("wait_drq abort aborted", last_aborted, 1);
        check("wait_drq abort no words", gos - g0, 0);
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        check("idle abort busy", busy, 0);
        check("idle abort no done", done_cnt - d0, 0);
        abort = 1'b0; drq = 1'b1;

        // num_sect=0 runs past two sectors; abort it after 600 words.
        exp_rnw = 1'b1; eng_delay = 1;
        g0 = gos; d0 = done_cnt;
        pulse_start(1'b1, 8'd0);
        check("aborted cleared by start", aborted, 0);
        wait_gos(g0 + 600, 5000, "num_sect 0 reaches word 600");
        check("num_sect 0 still busy", busy, 1);
        check("num_sect 0 no early done", done_cnt - d0, 0);
        abort = 1'b1;
        wait_done(d0, 50, "num_sect 0 abort done");
        check("num_sect 0 aborted", last_aborted, 1);
        abort = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while an engine cycle is outstanding.
        eng_delay = 10;
        g0 = gos; d0 = done_cnt;
        pulse_start(1'b1, 8'd1);
        wait_gos(g0 + 3, 200, "reset test reaches word 3");
        repeat (2) @(negedge clk);
        check("wait_end dma_req", dma_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset mid dma_req", dma_req, 0);
        check("reset mid busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("reset mid no done", done_cnt - d0, 0);
        check("reset mid idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ide_dma_seq.md
IDE_DMA_SEQ -- requirements
Module: ide_dma_seq

Interface
REQ-001 The block SHALL use clock clk and reset reset, synchronous, active-high, as decided.
REQ-002 SECT_WORDS, default 256, meaning words per sector.
REQ-003 clk  in  1  system clock, same domain as the IDE cycle engine.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
REQ-006 rnw  in  1  direction, latched at start: 1 = drive->memory, 0 = memory->drive.
REQ-007 num_sect  in  8  sector count, latched at start; 0 encodes 256.
REQ-008 abort  in  1  level request to stop at the next word boundary.
REQ-009 drq  in  1  drive data-request status, synchronous to clk.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse on return to IDLE.
REQ-012 aborted  out  1  set with done when the transfer ended by abort; cleared at next start.
REQ-013 dma_req, dma_rnw  out  1,1  request and direction to the IDE cycle engine.
REQ-014 dma_out  out  16  write word to the engine, registered.
REQ-015 ide_in  in  16  read data from the drive bus.
REQ-016 rdy, rdy_stb  in  1,1  engine idle and end-of-cycle strobe.
REQ-017 mem_wdata, mem_we  out  16,1  captured read word and its one-cycle strobe.
REQ-018 mem_rdata, mem_rvalid, mem_rready  in,in,out  16,1,1  valid/ready source of write words.

Function
REQ-019 States SHALL be IDLE, WAIT_DRQ, FETCH, ISSUE, WAIT_END, NEXT.
REQ-020 IDLE -> WAIT_DRQ on start; the block SHALL latch rnw and num_sect, clear the word counter, and clear aborted.
REQ-021 WAIT_DRQ -> ISSUE when drq=1 and rnw=1; WAIT_DRQ -> FETCH when drq=1 and rnw=0.
REQ-022 FETCH: mem_rready SHALL be asserted; on mem_rvalid & mem_rready, dma_out <= mem_rdata and the state SHALL become ISSUE.
REQ-023 ISSUE: dma_req SHALL rise, and dma_rnw SHALL equal the latched rnw; the state SHALL become WAIT_END.
REQ-024 dma_req SHALL stay high until rdy_stb is seen and SHALL be low in the cycle after rdy_stb, so the engine starts exactly one cycle per word.
REQ-025 On rdy_stb with rnw=1: mem_wdata <= ide_in, and mem_we SHALL pulse in the next cycle.
REQ-026 On rdy_stb the state SHALL become NEXT; NEXT SHALL increment the 8-bit word counter modulo 256.
REQ-027 In NEXT, if abort=1: the state SHALL become IDLE with done=1 and aborted=1.
REQ-028 In NEXT, if the counter wraps 255->0: the 9-bit sectors-left count SHALL decrement; at 0 the state SHALL become IDLE with done=1, otherwise WAIT_DRQ.
REQ-029 In NEXT with no abort and no wrap: the state SHALL become FETCH if rnw=0, or ISSUE if rnw=1.
REQ-030 num_sect=0 SHALL load sectors-left with 256.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort SHALL never cut an engine cycle short; abort in IDLE has no effect.
REQ-033 abort in WAIT_DRQ or FETCH SHALL end the transfer immediately with done=1 and aborted=1.
REQ-034 done and aborted SHALL never assert in the same cycle as start is accepted.

Reset
REQ-035 On reset, all outputs SHALL be 0, specifically: busy, done, aborted, dma_req, dma_rnw, mem_we, mem_rready, dma_out, mem_wdata.
REQ-036 On reset, the state SHALL be IDLE and the counters SHALL be 0.
REQ-037 Reset mid-transfer SHALL take effect in the next cycle; no done pulse follows.

Structure
REQ-038 The state enum and SECT_WORDS SHALL live in the shared ide package.
REQ-039 The design SHALL be a single module with no sub-module; the counters and FSM are in one file.

Verification
REQ-040 Read, num_sect=1, drq=1, engine model with rdy_stb 5 cycles after go -> 256 mem_we pulses carrying the model's data in order, then one done, aborted=0.
REQ-041 Write, num_sect=2, mem_rvalid toggling 50% -> 512 engine cycles; the dma_out sequence equals mem_rdata order; done after the 512th rdy_stb.
REQ-042 drq low for 20 cycles at the sector boundary -> no dma_req during the gap; transfer resumes when drq=1.
REQ-043 abort raised mid-word 10 -> exactly 11 engine cycles complete, then done=1 and aborted=1, busy=0.
REQ-044 num_sect=0 -> 65536 words transferred; start pulsed while busy -> ignored.
REQ-045 reset asserted during WAIT_END -> next cycle dma_req=0, busy=0, no done pulse.
